// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared arbiter definitions: mode encodings and a one-hot to
//                binary index helper used by this and later arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbitration mode select encodings
    typedef logic arb_mode_t;
    localparam arb_mode_t ARB_MODE_FIXED = 1'b0;
    localparam arb_mode_t ARB_MODE_RR    = 1'b1;

    // Widest request vector the index helper accepts
    localparam int c_ARB_MAX_N = 64;

    // OR-reduce the positions of all set bits; exact for a one-hot or zero input
    function automatic int unsigned onehot_to_idx(input logic [c_ARB_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < c_ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating priority picker. The request vector
//                is rotated so i_start_ptr lands at bit 0, the lowest set bit
//                is isolated, and the result is rotated back into place.
//                A start pointer of zero gives plain fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start_ptr,
    output logic [N-1:0]     o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [N-1:0] w_req_rot;
    logic [N-1:0] w_oh_rot;

    // Rotate right via a double-width shift, isolate lowest set bit, rotate back left
    always_comb begin
        w_req_rot  = N'({i_req, i_req} >> i_start_ptr);
        w_oh_rot   = w_req_rot & (~w_req_rot + N'(1));
        o_grant_oh = N'(({w_oh_rot, w_oh_rot} << i_start_ptr) >> N);
    end

    assign o_grant_idx = IDX_W'(onehot_to_idx(c_ARB_MAX_N'(o_grant_oh)));
    assign o_any       = |i_req;

endmodule
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_lock_arbiter
//  Description : Registered N-way arbiter with runtime fixed/round-robin mode,
//                registered one-hot grant, requester-driven lock and a bounded
//                hold timeout so a locked owner cannot starve the others.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // Counter needs at least one bit even when the timeout is disabled
    localparam int               c_HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    logic [N-1:0]     r_grant;
    logic             r_grant_valid;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_ptr;

    logic             w_timeout;
    logic             w_hold;
    logic [IDX_W-1:0] w_start_ptr;
    logic [N-1:0]     w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;

    // The owner keeps the grant only while it both requests and locks, and has
    // not used up its hold budget. grant_idx is 0 when idle, but the hold term
    // is gated by grant_valid so that index is harmless.
    assign w_hold = r_grant_valid && req[r_grant_idx] && lock[r_grant_idx] && !w_timeout;

    // Fixed mode is round robin that always starts at requester 0. In round
    // robin, ptr already sits at owner+1 during a hold, so a timeout naturally
    // puts the old owner last.
    assign w_start_ptr = (mode == ARB_MODE_RR) ? r_ptr : '0;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req       (req),
        .i_start_ptr (w_start_ptr),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx),
        .o_any       (w_pick_any)
    );

    generate
        if (MAX_HOLD != 0) begin : g_timeout
            logic [c_HC_W-1:0] r_hold_cnt;

            assign w_timeout = (r_hold_cnt == c_HC_W'(MAX_HOLD - 1));

            // Count consecutive held cycles; restart on every fresh grant, saturate at the limit
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold_cnt <= '0;
                end else if (w_hold) begin
                    if (!w_timeout) begin
                        r_hold_cnt <= r_hold_cnt + c_HC_W'(1);
                    end
                end else if (w_pick_any) begin
                    r_hold_cnt <= '0;
                end
            end
        end else begin : g_no_timeout
            // Unlimited hold: a lock is only broken by the owner itself
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Grant register: keep on hold, otherwise load the picker result or go idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_ptr         <= '0;
        end else if (w_hold) begin
            r_grant       <= r_grant;
            r_grant_valid <= r_grant_valid;
            r_grant_idx   <= r_grant_idx;
        end else if (w_pick_any) begin
            r_grant       <= w_pick_oh;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_pick_idx;
            r_ptr         <= (w_pick_idx == c_LAST) ? '0 : w_pick_idx + IDX_W'(1);
        end else begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_lock_arbiter
//  Description : Self-checking bench for rr_lock_arbiter. Two instances share
//                stimulus: MAX_HOLD=4 and MAX_HOLD=0 (unlimited lock).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [N-1:0]     req;
    logic [N-1:0]     lock;
    logic [N-1:0]     grant0, grant1;
    logic             gv0, gv1;
    logic [IDX_W-1:0] idx0, idx1;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.N(N), .MAX_HOLD(4)) u_dut0 (
        .clk (clk), .rst (rst), .mode (mode), .req (req), .lock (lock),
        .grant (grant0), .grant_valid (gv0), .grant_idx (idx0)
    );

    rr_lock_arbiter #(.N(N), .MAX_HOLD(0)) u_dut1 (
        .clk (clk), .rst (rst), .mode (mode), .req (req), .lock (lock),
        .grant (grant1), .grant_valid (gv1), .grant_idx (idx1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state per instance: owner (-1 idle), RR pointer, held cycles
    int m_owner [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_limit [2];

    // Starvation tracking for instance 0 in round-robin phases
    bit starve_en = 1'b0;
    int wait_cnt [N];
    int max_wait = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the arbitration rules, evaluated on the inputs seen at the edge
    function automatic void model_step(input int d);
        bit timeout;
        bit hold;
        int start;
        int win;
        if (rst) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_cnt[d]   = 0;
            return;
        end
        timeout = (m_limit[d] != 0) && (m_cnt[d] == m_limit[d] - 1);
        hold    = (m_owner[d] >= 0) && req[m_owner[d]] && lock[m_owner[d]] && !timeout;
        if (hold) begin
            m_cnt[d] = m_cnt[d] + 1;
            return;
        end
        start = mode ? m_ptr[d] : 0;
        win   = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && req[(start + k) % N]) win = (start + k) % N;
        end
        if (win >= 0) begin
            m_owner[d] = win;
            m_cnt[d]   = 0;
            m_ptr[d]   = (win + 1) % N;
        end else begin
            m_owner[d] = -1;
        end
    endfunction

    function automatic logic [N-1:0] model_grant(input int d);
        logic [N-1:0] g;
        g = '0;
        if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
        return g;
    endfunction

    task automatic check_dut(input int d, input logic [N-1:0] g, input logic v,
                             input logic [IDX_W-1:0] ix);
        check(d == 0 ? "m0_grant" : "m1_grant", 32'(g), 32'(model_grant(d)));
        check(d == 0 ? "m0_valid" : "m1_valid", 32'(v), 32'(m_owner[d] >= 0));
        check(d == 0 ? "m0_idx" : "m1_idx", 32'(ix), (m_owner[d] < 0) ? 0 : m_owner[d]);
        check(d == 0 ? "m0_onehot0" : "m1_onehot0", 32'($onehot0(g)), 32'(1));
    endtask

    // Advance one clock, update the reference, then sample outputs 1ns later
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0, grant0, gv0, idx0);
        check_dut(1, grant1, gv1, idx1);
        if (starve_en) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant0[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    initial begin
        m_limit[0] = 4;
        m_limit[1] = 0;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_cnt[d]   = 0;
        end
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        rst = 1'b1; mode = 1'b0; req = '0; lock = '0;

        // Reset state
        tick();
        check("rst_grant", 32'(grant0), 32'h0);
        check("rst_valid", 32'(gv0), 32'h0);
        check("rst_idx", 32'(idx0), 32'h0);

        // Fixed priority: lowest set index wins and keeps winning
        rst = 1'b0; mode = 1'b0; req = 4'b1010;
        repeat (4) begin
            tick();
            check("fix_grant", 32'(grant0), 32'h2);
            check("fix_idx", 32'(idx0), 32'h1);
        end

        // Round robin rotation with wrap
        rst = 1'b1; tick();
        rst = 1'b0; mode = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_rot", 32'(grant0), 32'(1 << (k % N)));
        end

        // Lock with timeout (inst 0) and unlimited lock (inst 1)
        rst = 1'b1; req = '0; tick();
        rst = 1'b0; mode = 1'b1; req = 4'b0011; lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("to_hold", 32'(grant0), 32'h1);
            check("nl_hold", 32'(grant1), 32'h1);
        end
        tick();
        check("to_switch", 32'(grant0), 32'h2);
        check("nl_hold", 32'(grant1), 32'h1);
        repeat (2) begin
            tick();
            check("nl_hold", 32'(grant1), 32'h1);
        end
        lock = '0; tick();
        check("nl_release", 32'(grant1), 32'h2);

        // Release handover from locked owner 2 to requester 3 with no idle cycle
        rst = 1'b1; req = '0; tick();
        rst = 1'b0; mode = 1'b1; req = 4'b0100; lock = 4'b0100;
        tick();
        check("ho_own", 32'(grant0), 32'h4);
        req = 4'b1101; tick();
        check("ho_held", 32'(grant0), 32'h4);
        req = 4'b1001; tick();
        check("ho_grant", 32'(grant0), 32'h8);
        check("ho_valid", 32'(gv0), 32'h1);
        req = '0; lock = '0; tick();
        check("idle_grant", 32'(grant0), 32'h0);
        check("idle_valid", 32'(gv0), 32'h0);

        // Reset while a grant is active, then restart round robin from 0
        req = 4'b0100; tick();
        check("mid_own", 32'(grant0), 32'h4);
        rst = 1'b1; tick();
        check("mid_rst_grant", 32'(grant0), 32'h0);
        check("mid_rst_valid", 32'(gv0), 32'h0);
        check("mid_rst_idx", 32'(idx0), 32'h0);
        rst = 1'b0; mode = 1'b1; req = 4'b1111; tick();
        check("post_rst", 32'(grant0), 32'h1);

        // Mode change never breaks an active hold
        req = 4'b0011; lock = 4'b0001; mode = 1'b0; tick();
        check("mode_hold", 32'(grant0), 32'h1);

        // Round-robin soak with sticky requests for the starvation bound
        mode = 1'b1; starve_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            lock = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom());
            tick();
        end
        starve_en = 1'b0;
        check("rr_starve", 32'(max_wait <= (N - 1) * 4 + N), 32'h1);

        // Fully random soak including mode flips and occasional reset
        for (int c = 0; c < 10000; c++) begin
            req  = 4'($urandom());
            lock = 4'($urandom());
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            rst  = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
